// File: rtl/config_load_sequencer_pkg.sv
// Shared definitions for the configuration load sequencer: state encoding,
// header field positions and write-target indices.
package config_load_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Header word layout
    localparam int TGT_MSB  = 31;
    localparam int TGT_LSB  = 28;
    localparam int CNT_MSB  = 15;
    localparam int ADDR_MSB = 15;

    localparam int TGT_CFG_A     = 0;
    localparam int TGT_CFG_B     = 1;
    localparam int TGT_AER       = 2;
    localparam int TGT_AXON_MODE = 8;

endpackage

// File: rtl/config_load_sequencer.sv
// Streams header+data words into the neuron core config memories as registered
// one-hot write strobes. Define CFG_LOAD_CHECKSUM_EN for a trailing XOR check word.
//
// state | meaning
// IDLE  | waiting for H0 (target, count)
// HDR1  | waiting for H1 (start address)
// DATA  | one write per accepted word, address auto-increments
// CSUM  | waiting for XOR check word (checksum build only)
// DONE  | one-cycle completion pulse
module config_load_sequencer
    import config_load_sequencer_pkg::*;
#(
    parameter int DSIZE                   = 16,
    parameter int NURN_CNT_BIT_WIDTH      = 8,
    parameter int AXON_CNT_BIT_WIDTH      = 8,
    parameter int CONFIG_PARAMETER_NUMBER = 9,
    parameter int WIDE_TARGET             = TGT_AXON_MODE
) (
    input  logic                                             clk_i,
    input  logic                                             rst_n_i,
    input  logic [31:0]                                      cfg_data_i,
    input  logic                                             cfg_valid_i,
    output logic                                             cfg_ready_o,
    input  logic                                             hold_i,
    output logic [DSIZE*2-1:0]                               config_data_o,
    output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] cfg_addr_o,
    output logic [CONFIG_PARAMETER_NUMBER-1:0]               config_write_enable_o,
    output logic                                             ce_o,
    output logic                                             busy_o,
    output logic                                             done_o,
    output logic                                             err_o,
    input  logic                                             err_clr_i
);
    localparam int AW = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;
    localparam int DW = DSIZE * 2;
    localparam int CW = CNT_MSB + 1;
    localparam int TW = TGT_MSB - TGT_LSB + 1;
    localparam logic [AW-1:0] NURN_MASK = {{AXON_CNT_BIT_WIDTH{1'b0}}, {NURN_CNT_BIT_WIDTH{1'b1}}};

    state_e                               state_q, state_d;
    logic [TW-1:0]                        tgt_q, tgt_d;
    logic                                 tgt_ok_q, tgt_ok_d;
    logic                                 wide_q, wide_d;
    logic [CW-1:0]                        rem_q, rem_d;
    logic [AW-1:0]                        ptr_q, ptr_d, ptr_inc;
    logic [DW-1:0]                        wdata_q, wdata_d;
    logic [AW-1:0]                        waddr_q, waddr_d;
    logic [CONFIG_PARAMETER_NUMBER-1:0]   we_q, we_d;
    logic                                 err_q, err_d, set_err;
    logic                                 accept;
    logic [TW-1:0]                        hdr_tgt;
    logic [CW-1:0]                        hdr_cnt;
`ifdef CFG_LOAD_CHECKSUM_EN
    logic [31:0]                          csum_q, csum_d;
`endif

    // Gated by reset so ready stays low while the block is held in reset.
    assign cfg_ready_o = rst_n_i & ~hold_i & (state_q != ST_DONE);
    assign accept      = cfg_valid_i & cfg_ready_o;
    assign hdr_tgt     = cfg_data_i[TGT_MSB:TGT_LSB];
    assign hdr_cnt     = cfg_data_i[CNT_MSB:0];
    assign ptr_inc     = wide_q ? ptr_q + AW'(1) : (ptr_q + AW'(1)) & NURN_MASK;

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        tgt_ok_d = tgt_ok_q;
        wide_d   = wide_q;
        rem_d    = rem_q;
        ptr_d    = ptr_q;
        wdata_d  = wdata_q;
        waddr_d  = waddr_q;
        we_d     = '0;
        set_err  = 1'b0;
`ifdef CFG_LOAD_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            ST_IDLE: if (accept) begin
                tgt_d    = hdr_tgt;
                tgt_ok_d = (32'(hdr_tgt) < CONFIG_PARAMETER_NUMBER);
                wide_d   = (32'(hdr_tgt) == WIDE_TARGET);
                rem_d    = hdr_cnt;
                if (32'(hdr_tgt) >= CONFIG_PARAMETER_NUMBER) set_err = 1'b1;
                if (hdr_cnt == '0) set_err = 1'b1;
                else               state_d = ST_HDR1;
            end
            ST_HDR1: if (accept) begin
                ptr_d   = AW'(cfg_data_i[ADDR_MSB:0]);
                if (!wide_q) ptr_d = ptr_d & NURN_MASK;
                state_d = ST_DATA;
`ifdef CFG_LOAD_CHECKSUM_EN
                csum_d  = '0;
`endif
            end
            ST_DATA: if (accept) begin
                // Illegal targets are still consumed word for word, just never strobed.
                if (tgt_ok_q) we_d = CONFIG_PARAMETER_NUMBER'(1) << tgt_q;
                wdata_d = DW'(cfg_data_i);
                waddr_d = ptr_q;
                ptr_d   = ptr_inc;
                rem_d   = rem_q - CW'(1);
`ifdef CFG_LOAD_CHECKSUM_EN
                csum_d  = csum_q ^ cfg_data_i;
                if (rem_q == CW'(1)) state_d = ST_CSUM;
`else
                if (rem_q == CW'(1)) state_d = ST_DONE;
`endif
            end
`ifdef CFG_LOAD_CHECKSUM_EN
            ST_CSUM: if (accept) begin
                if (cfg_data_i != csum_q) set_err = 1'b1;
                state_d = ST_DONE;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        err_d = err_clr_i ? 1'b0 : err_q;
        if (set_err) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            tgt_q    <= '0;
            tgt_ok_q <= 1'b0;
            wide_q   <= 1'b0;
            rem_q    <= '0;
            ptr_q    <= '0;
            wdata_q  <= '0;
            waddr_q  <= '0;
            we_q     <= '0;
            err_q    <= 1'b0;
`ifdef CFG_LOAD_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            tgt_ok_q <= tgt_ok_d;
            wide_q   <= wide_d;
            rem_q    <= rem_d;
            ptr_q    <= ptr_d;
            wdata_q  <= wdata_d;
            waddr_q  <= waddr_d;
            we_q     <= we_d;
            err_q    <= err_d;
`ifdef CFG_LOAD_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign config_data_o         = wdata_q;
    assign cfg_addr_o            = waddr_q;
    assign config_write_enable_o = we_q;
    assign ce_o                  = |we_q;
    assign busy_o                = (state_q != ST_IDLE);
    assign done_o                = (state_q == ST_DONE);
    assign err_o                 = err_q;

endmodule

// File: tb/tb_config_load_sequencer.sv
// Directed bench for config_load_sequencer; expected writes go through a
// scoreboard queue and are matched against strobes every falling edge.
module tb_config_load_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        hold;
    logic [31:0] cfg_wdata;
    logic [15:0] cfg_addr;
    logic [8:0]  cfg_we;
    logic        ce, busy, done, err, err_clr;

    always #5 clk = ~clk;

    config_load_sequencer dut (
        .clk_i                 (clk),
        .rst_n_i               (rst_n),
        .cfg_data_i            (cfg_data),
        .cfg_valid_i           (cfg_valid),
        .cfg_ready_o           (cfg_ready),
        .hold_i                (hold),
        .config_data_o         (cfg_wdata),
        .cfg_addr_o            (cfg_addr),
        .config_write_enable_o (cfg_we),
        .ce_o                  (ce),
        .busy_o                (busy),
        .done_o                (done),
        .err_o                 (err),
        .err_clr_i             (err_clr)
    );

    typedef struct {
        logic [3:0]  t;
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic [31:0] bd[8];
    bit          bad_csum = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (done === 1'b1) done_cnt++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("strobe_ce", 32'(ce), 32'd1);
            chk("strobe_we", 32'(cfg_we), 32'd1 << e.t);
            chk("strobe_addr", 32'(cfg_addr), 32'(e.a));
            chk("strobe_data", cfg_wdata, e.d);
        end else begin
            chk("no_strobe", {22'd0, ce, cfg_we}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [31:0] w, input bit wr, input logic [3:0] t, input logic [15:0] a);
        bit rdy;
        bit got = 0;
        cfg_valid = 1'b1;
        cfg_data  = w;
        for (int k = 0; k < 50 && !got; k++) begin
            #1;
            rdy = cfg_ready;
            @(posedge clk);
            if (rdy) begin
                got = 1;
                if (wr) sb.push_back('{t, a, w});
            end
            @(negedge clk);
        end
        chk("send_accepted", 32'(got), 32'd1);
    endtask

    task automatic do_hold(input int cycles);
        hold      = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = bd[1];
        for (int c = 0; c < cycles; c++) begin
            #1;
            chk("hold_ready", 32'(cfg_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        hold = 1'b0;
    endtask

    task automatic block(input logic [3:0] t, input logic [15:0] n, input logic [15:0] a, input int hold_cycles);
        bit          legal = (t < 4'd9);
        bit          wide  = (t == 4'd8);
        logic [15:0] addr;
        logic [31:0] x = '0;
        send({t, 12'h000, n}, 0, t, a);
        send({16'h0, a}, 0, t, a);
        for (int i = 0; i < int'(n); i++) begin
            addr = wide ? a + 16'(i) : {8'h00, a[7:0] + 8'(i)};
            x    = x ^ bd[i];
            send(bd[i], legal, t, addr);
            if (i == 0 && hold_cycles > 0) do_hold(hold_cycles);
        end
`ifdef CFG_LOAD_CHECKSUM_EN
        send(bad_csum ? x ^ 32'h1 : x, 0, t, a);
`endif
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        repeat (3) @(negedge clk);
        chk(tag, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("err_cleared", 32'(err), 32'd0);
    endtask

    initial begin
        int d0;
        rst_n     = 1'b0;
        cfg_data  = '0;
        cfg_valid = 1'b0;
        hold      = 1'b0;
        err_clr   = 1'b0;
        #3;
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_outs", {26'd0, busy, done, err, ce, 2'd0}, 32'd0);
        #9 rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(cfg_ready), 32'd1);
        chk("rel_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Neuron-address wrap on target 0
        bd[0] = 32'h11; bd[1] = 32'h22; bd[2] = 32'h33;
        d0 = done_cnt;
        block(4'd0, 16'd3, 16'h00FE, 0);
        wait_done("t0_done", d0);
        chk("t0_err", 32'(err), 32'd0);

        // Full-width wrap on the wide target
        bd[0] = 32'hA5A5_0001; bd[1] = 32'h5A5A_0002;
        d0 = done_cnt;
        block(4'd8, 16'd2, 16'hFFFF, 0);
        wait_done("wide_done", d0);
        chk("wide_err", 32'(err), 32'd0);

        // Illegal target consumed without strobes, error sticky
        bd[0] = 32'hDEAD_0000; bd[1] = 32'hBEEF_0000;
        d0 = done_cnt;
        block(4'd12, 16'd2, 16'h0010, 0);
        wait_done("illegal_done", d0);
        chk("illegal_err", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        chk("illegal_err_sticky", 32'(err), 32'd1);
        clear_err();

        // Zero-count header flags error and stays idle
        send({4'd3, 12'h000, 16'h0000}, 0, 4'd3, 16'h0);
        cfg_valid = 1'b0;
        #1;
        chk("zero_cnt_err", 32'(err), 32'd1);
        chk("zero_cnt_idle", 32'(busy), 32'd0);
        @(negedge clk);
        clear_err();

        // Hold for 5 cycles after first data word
        bd[0] = 32'h100; bd[1] = 32'h101; bd[2] = 32'h102; bd[3] = 32'h103;
        d0 = done_cnt;
        block(4'd1, 16'd4, 16'h0040, 5);
        wait_done("hold_done", d0);
        chk("hold_err", 32'(err), 32'd0);

        // Reset mid-block after 2 of 4 data words
        send({4'd1, 12'h000, 16'd4}, 0, 4'd1, 16'h0);
        send(32'h0000_0020, 0, 4'd1, 16'h0);
        send(32'h0000_0AAA, 1, 4'd1, 16'h0020);
        send(32'h0000_0BBB, 1, 4'd1, 16'h0021);
        #2;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        #1;
        chk("midrst_ready", 32'(cfg_ready), 32'd0);
        chk("midrst_flags", {28'd0, busy, done, err, ce}, 32'd0);
        chk("midrst_we", 32'(cfg_we), 32'd0);
        chk("midrst_addr", 32'(cfg_addr), 32'd0);
        chk("midrst_data", cfg_wdata, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("midrst_rel_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        bd[0] = 32'h0000_0C0C;
        d0 = done_cnt;
        block(4'd2, 16'd1, 16'h0005, 0);
        wait_done("fresh_done", d0);
        chk("fresh_err", 32'(err), 32'd0);

`ifdef CFG_LOAD_CHECKSUM_EN
        bd[0] = 32'h1; bd[1] = 32'h2;
        bad_csum = 0;
        d0 = done_cnt;
        block(4'd0, 16'd2, 16'h0080, 0);
        wait_done("csum_ok_done", d0);
        chk("csum_ok_err", 32'(err), 32'd0);
        bad_csum = 1;
        d0 = done_cnt;
        block(4'd0, 16'd2, 16'h0080, 0);
        wait_done("csum_bad_done", d0);
        chk("csum_bad_err", 32'(err), 32'd1);
        clear_err();
`endif

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/config_load_sequencer.md
Name: config_load_sequencer

Overview:
- Sequences configuration writes into the neuron core's configuration memories. Targets: STDP/learning-rate memory, neuron-type/threshold/reset memory, AER memory, axon learning-mode memory, and the count registers.
- Accepts a 32-bit word stream over valid/ready. Decodes a two-word header (target, count, start address), then issues one registered write strobe per data word with an auto-incrementing address.
- Arbitrates against the neuron pipeline: when the pipeline holds the config memories, the loader stalls.

Parameters:
- DSIZE, 16, datapath width; config_data_o is DSIZE*2 bits
- NURN_CNT_BIT_WIDTH, 8, neuron address width
- AXON_CNT_BIT_WIDTH, 8, axon address width
- CONFIG_PARAMETER_NUMBER, 9, number of write targets (one-hot strobe width)
- WIDE_TARGET, 8, target index addressed with the full neuron+axon address; all others use the neuron address only

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- cfg_data_i  in  32  stream word
- cfg_valid_i  in  1  word valid
- cfg_ready_o  out  1  word accepted when valid&ready at posedge
- hold_i  in  1  pipeline owns config memories; loader must not accept or write
- config_data_o  out  DSIZE*2  write data
- cfg_addr_o  out  NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH  write address
- config_write_enable_o  out  CONFIG_PARAMETER_NUMBER  one-hot write strobe
- ce_o  out  1  memory chip enable (= OR of strobe)
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse when a block completes
- err_o  out  1  sticky error flag
- err_clr_i  in  1  clears err_o

Behaviour:
- Reset (async, any time, including mid-block): state=IDLE, and all outputs are 0. Exception: cfg_ready_o becomes 1 on the first cycle after reset release if hold_i=0. Memory contents already written are retained; a partially loaded block is abandoned.
- cfg_ready_o = ~hold_i & (state in IDLE, HDR1, DATA, CSUM). It is 0 in DONE.
- States:
  - IDLE: accepted word is H0. H0[31:28]=target T, H0[15:0]=count N. N=0 -> set err, stay IDLE. Else go to HDR1.
  - HDR1: accepted word is H1. H1[15:0]=start address A. Go to DATA with addr=A and remaining=N.
  - DATA: each accepted word D is issued as a write.
    - Next cycle: config_data_o=D[DSIZE*2-1:0], cfg_addr_o=addr, config_write_enable_o bit T=1 for exactly one cycle, ce_o=1.
    - Then addr increments and remaining decrements.
    - After the Nth word: go to CSUM if the feature is enabled, else DONE.
  - DONE: one cycle. done_o=1, then IDLE.
- Write latency: exactly 1 cycle from handshake to strobe. Back-to-back words give back-to-back strobes.
- Illegal target (T>=CONFIG_PARAMETER_NUMBER):
  - err set when H0 is accepted.
  - The block is still consumed: HDR1 and N data words are accepted with no strobes, then DONE.
- Address wrap:
  - T==WIDE_TARGET: addr wraps modulo 2^(NURN+AXON).
  - Otherwise: addr[NURN-1:0] wraps modulo 2^NURN and the upper bits are forced to 0.
- hold_i:
  - Asserting it mid-block freezes state, addr and remaining; ready=0.
  - A strobe already registered from the previous cycle still completes, because hold only blocks new acceptances.
- err_o is sticky until err_clr_i. If err_clr_i and a new error occur in the same cycle, the error wins.

Optional Feature:
- Macro: CFG_LOAD_CHECKSUM_EN.
- With the macro: after the Nth data word the sequencer waits in CSUM for one extra word, which is a 32-bit XOR of all data words.
  - Mismatch sets err_o.
  - Writes already performed are not undone.
  - done_o pulses either way.
- Without the macro: no CSUM state; DATA goes directly to DONE.

Decomposition:
- Shared package/define file:
  - state encoding localparams IDLE/HDR1/DATA/CSUM/DONE
  - header field positions (TGT_MSB=31, TGT_LSB=28, CNT_MSB=15, ADDR_MSB=15)
  - target index constants (e.g. TGT_CFG_A=0, TGT_CFG_B=1, TGT_AER=2, TGT_AXON_MODE=8)
- No sub-module is needed. The checksum accumulator is a local register under the macro.

Test Plan:
- H0={4'd0,N=3}, H1=A=0x00FE, data 0x11,0x22,0x33 -> strobe bit0 for 3 consecutive cycles. Addrs 0x00FE, 0x00FF, 0x0000 (neuron wrap). done_o pulses once, err_o=0.
- Target 8, A=0xFFFF, N=2 -> addrs 0xFFFF then 0x0000, with strobe bit8.
- Target 12, N=2 -> 4 words accepted, no strobe, err_o=1 until err_clr_i.
- hold_i high for 5 cycles after the 1st data word (N=4) -> ready=0 and no strobe during hold. Remaining 3 writes then resume at the correct addresses.
- Reset asserted after 2 of 4 data words -> all outputs 0 immediately. The next H0 is accepted as a fresh header.
- (CHECKSUM_EN) data 0x1,0x2 with csum 0x3 -> err_o=0; repeat with csum 0x4 -> err_o=1, done_o still pulses.
